seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the shared seven_seg_display decoder.

---
 rtl/seven_seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one nibble and one
// active-low anode per slot, guard gaps, frame-aligned score commits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_WIDTH1  = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_load,
  input  logic [NUM_DIGITS*DATA_WIDTH1-1:0] i_value,
  input  logic                              i_blank_lz,
  output logic [DATA_WIDTH1-1:0]            o_hex,
  output logic [NUM_DIGITS-1:0]             o_anode,
  output logic                              o_load_pend,
  output logic                              o_load_ack,
  output logic                              o_frame_done
);

  localparam int VW   = NUM_DIGITS * DATA_WIDTH1;
  localparam int CMAX = (REFRESH_DIV > GUARD_CYCLES) ?
                        REFRESH_DIV : GUARD_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_SCAN,
    S_GUARD
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   wrap;
  logic                   boundary;
  logic [VW-1:0]          disp, disp_n;
  logic [VW-1:0]          pend_val;
  logic [NUM_DIGITS-1:0]  nz;
  logic [DATA_WIDTH1-1:0] hex_n;
  logic [NUM_DIGITS-1:0]  anode_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_SCAN;
      cnt      <= '0;
      idx      <= '0;
      boundary <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      boundary <= wrap;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    wrap    = 1'b0;
    unique case (state)
      S_SCAN: begin
        if (cnt == REF_LAST) begin
          state_n = S_GUARD;
          cnt_n   = '0;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt == GRD_LAST) begin
          state_n = S_SCAN;
          cnt_n   = '0;
          wrap    = (idx == '0);
        end
      end
    endcase
  end

  // Outputs lag the state by one cycle; hex uses the post-commit score
  // so the first digit of a new frame already shows the new value.
  always_comb begin
    disp_n = (boundary && o_load_pend) ? pend_val : disp;
    nz     = '0;
    hex_n  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nz[k] = |(disp_n >> (k * DATA_WIDTH1));
      if (idx == IW'(k)) hex_n = disp_n[k*DATA_WIDTH1 +: DATA_WIDTH1];
    end
    anode_n = '1;
    if (state == S_SCAN &&
        (!i_blank_lz || nz[idx] || idx == '0))
      anode_n[idx] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_anode      <= '1;
      o_hex        <= '0;
      o_load_pend  <= 1'b0;
      o_load_ack   <= 1'b0;
      o_frame_done <= 1'b0;
      disp         <= '0;
      pend_val     <= '0;
    end else begin
      o_anode      <= anode_n;
      o_hex        <= hex_n;
      o_frame_done <= boundary;
      o_load_ack   <= boundary & o_load_pend;
      o_load_pend  <= i_load | (o_load_pend & ~boundary);
      disp         <= disp_n;
      if (i_load) pend_val <= i_value;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus randomized
// traffic against a cycle-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int W = 4;
  localparam int R = 4;
  localparam int G = 1;
  localparam int S = R + G;
  localparam int F = N * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  hex;
  logic [3:0]  anode;
  logic        pend;
  logic        ack;
  logic        fd;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(N),
    .DATA_WIDTH1(W),
    .REFRESH_DIV(R),
    .GUARD_CYCLES(G)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_load(load),
    .i_value(value),
    .i_blank_lz(blank),
    .o_hex(hex),
    .o_anode(anode),
    .o_load_pend(pend),
    .o_load_ack(ack),
    .o_frame_done(fd)
  );

  int checks = 0;
  int errors = 0;

  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pval;
  bit          m_pend;
  bit          m_ack;
  bit          m_fd;
  logic [3:0]  e_anode;
  logic [3:0]  e_hex;

  function automatic int pos();
    return (t - 1) % F;
  endfunction

  function automatic logic [3:0] digit(logic [15:0] v, int k);
    return v[4*k +: 4];
  endfunction

  task automatic calc(bit bl);
    int p, d, w;
    if (t == 0) begin
      e_anode = 4'hF;
      e_hex   = 4'h0;
    end else begin
      p = (t - 1) % F;
      d = p / S;
      w = p % S;
      e_anode = 4'hF;
      if (w < R) begin
        e_hex = digit(m_disp, d);
        if (!bl || d == 0 || (m_disp >> (4 * d)) != 0)
          e_anode[d] = 1'b0;
      end else begin
        e_hex = digit(m_disp, (d + 1) % N);
      end
    end
  endtask

  // Advance one clock and update the model with the inputs of that cycle.
  task automatic tick();
    bit          c_rst = rst;
    bit          c_ld  = load;
    bit          c_bl  = blank;
    logic [15:0] c_v   = value;
    bit          bnd;
    @(posedge clk);
    #1;
    if (c_rst) begin
      t = 0; m_disp = '0; m_pval = '0;
      m_pend = 0; m_ack = 0; m_fd = 0;
    end else begin
      bnd    = (t > 0) && (t % F == 0);
      m_ack  = bnd && m_pend;
      m_fd   = bnd;
      if (bnd && m_pend) m_disp = m_pval;
      if (c_ld) begin
        m_pval = c_v;
        m_pend = 1;
      end else if (bnd) begin
        m_pend = 0;
      end
      t++;
    end
    calc(c_bl);
  endtask

  task automatic goto_pos(int p);
    int n = 0;
    while (pos() != p && n <= F + 1) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!ack && n < 2 * F + 2) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1; load = 0; blank = 0; value = '0;
    tick(); tick();
    checks++; if (anode !== 4'hF) begin errors++; $display("FAIL rst_anode got %b want 1111", anode); end
    checks++; if (hex !== 4'h0) begin errors++; $display("FAIL rst_hex got %h want 0", hex); end
    checks++; if ({pend, ack, fd} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {pend, ack, fd}); end
    rst = 0;
    tick();
    checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL first_lit got %b want 1110", anode); end
  endtask

  task automatic test_scan();
    logic [3:0] pat [F];
    for (int d = 0; d < N; d++)
      for (int w = 0; w < S; w++)
        pat[d*S + w] = (w < R) ? ~(4'b0001 << d) : 4'hF;
    for (int i = 0; i < 2 * F + 5; i++) begin
      checks++;
      if (anode !== pat[pos()]) begin errors++; $display("FAIL scan_anode t=%0d got %b want %b", t, anode, pat[pos()]); end
      checks++;
      if (fd !== (t > 1 && pos() == 0)) begin errors++; $display("FAIL scan_fd t=%0d got %b", t, fd); end
      tick();
    end
  endtask

  task automatic test_load();
    logic [3:0] exp [N] = '{4'h2, 4'h4, 4'h0, 4'h0};
    int n, acks;
    goto_pos(7);
    value = 16'h0042; load = 1;
    tick();
    load = 0;
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL load_pend got %b want 1", pend); end
    wait_ack(n);
    checks++; if (ack !== 1'b1 || fd !== 1'b1) begin errors++; $display("FAIL load_ack ack=%b fd=%b want 1 1", ack, fd); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL load_clear got %b want 0", pend); end
    acks = 0;
    for (int i = 0; i < F; i++) begin
      if (i % S == 0) begin
        checks++;
        if (hex !== exp[i/S]) begin errors++; $display("FAIL load_hex d%0d got %h want %h", i / S, hex, exp[i/S]); end
      end
      if (ack) acks++;
      tick();
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL load_ackcnt got %0d want 1", acks); end
  endtask

  task automatic test_multi();
    logic [15:0] vals [3] = '{16'h0011, 16'h0022, 16'h0099};
    int acks = 0;
    goto_pos(2);
    for (int i = 0; i < 3; i++) begin
      value = vals[i]; load = 1;
      tick();
      load = 0;
      tick();
    end
    for (int i = 0; i < 2 * F; i++) begin
      if (ack) acks++;
      tick();
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL multi_ackcnt got %0d want 1", acks); end
    goto_pos(0);
    checks++; if (hex !== 4'h9) begin errors++; $display("FAIL multi_d0 got %h want 9", hex); end
    goto_pos(S);
    checks++; if (hex !== 4'h9) begin errors++; $display("FAIL multi_d1 got %h want 9", hex); end
    goto_pos(2 * S);
    checks++; if (hex !== 4'h0) begin errors++; $display("FAIL multi_d2 got %h want 0", hex); end
  endtask

  task automatic test_blank();
    int n;
    logic [3:0] want;
    blank = 1;
    goto_pos(3);
    value = 16'h0007; load = 1;
    tick();
    load = 0;
    wait_ack(n);
    checks++; if (hex !== 4'h7) begin errors++; $display("FAIL blank_hex got %h want 7", hex); end
    for (int i = 0; i < F; i++) begin
      want = (i < R) ? 4'b1110 : 4'hF;
      checks++;
      if (anode !== want) begin errors++; $display("FAIL blank_anode p%0d got %b want %b", i, anode, want); end
      tick();
    end
    value = 16'h0000; load = 1;
    tick();
    load = 0;
    wait_ack(n);
    checks++; if (anode !== 4'b1110 || hex !== 4'h0) begin errors++; $display("FAIL blank_zero anode=%b hex=%h want 1110 0", anode, hex); end
    goto_pos(S);
    checks++; if (anode !== 4'hF) begin errors++; $display("FAIL blank_zero_d1 got %b want 1111", anode); end
    blank = 0;
  endtask

  task automatic test_boundary();
    int n;
    goto_pos(3);
    value = 16'h1234; load = 1;
    tick();
    load = 0;
    goto_pos(F - 1);
    value = 16'h5678; load = 1;
    tick();
    load = 0;
    checks++; if ({ack, fd, pend} !== 3'b111) begin errors++; $display("FAIL bnd_flags got %b want 111", {ack, fd, pend}); end
    checks++; if (hex !== 4'h4) begin errors++; $display("FAIL bnd_old_hex got %h want 4", hex); end
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 2 * F);
    checks++; if (n != F) begin errors++; $display("FAIL bnd_gap got %0d want %0d", n, F); end
    checks++; if (hex !== 4'h8 || pend !== 1'b0) begin errors++; $display("FAIL bnd_new hex=%h pend=%b want 8 0", hex, pend); end
  endtask

  task automatic test_mid_reset();
    int acks = 0;
    goto_pos(1);
    value = 16'h0333; load = 1;
    tick();
    load = 0;
    goto_pos(2 * S + 1);
    rst = 1;
    tick();
    rst = 0;
    checks++; if (anode !== 4'hF || pend !== 1'b0) begin errors++; $display("FAIL mrst anode=%b pend=%b want 1111 0", anode, pend); end
    tick();
    checks++; if (anode !== 4'b1110 || hex !== 4'h0) begin errors++; $display("FAIL mrst_d0 anode=%b hex=%h want 1110 0", anode, hex); end
    for (int i = 0; i < 2 * F; i++) begin
      if (ack) acks++;
      tick();
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL mrst_ack got %0d want 0", acks); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load  = ($urandom % 6) == 0;
      value = 16'($urandom);
      if ($urandom % 8 == 0) value = value & 16'h00FF;
      if ($urandom % 40 == 0) blank = ~blank;
      rst   = ($urandom % 200) == 0;
      tick();
      checks++;
      if (anode !== e_anode || hex !== e_hex) begin errors++; $display("FAIL rnd_disp t=%0d anode=%b hex=%h want %b %h", t, anode, hex, e_anode, e_hex); end
      checks++;
      if ({pend, ack, fd} !== {m_pend, m_ack, m_fd}) begin errors++; $display("FAIL rnd_flags t=%0d got %b want %b", t, {pend, ack, fd}, {m_pend, m_ack, m_fd}); end
    end
    rst = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_multi();
    test_blank();
    test_boundary();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
